// File: rtl/sample_stream_fifo_if.sv
// rtl/sample_stream_fifo_if.sv - stream, flush and status bundle for sample_stream_fifo
// master drives the input stream and the sink ready; slave is the FIFO side.
interface sample_stream_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int AW = $clog2(DEPTH);

    logic                  flush;
    logic                  stream_in_valid;
    logic                  stream_in_ready;
    logic [DATA_WIDTH-1:0] stream_in_data;
    logic                  stream_out_valid;
    logic                  stream_out_ready;
    logic [DATA_WIDTH-1:0] stream_out_data;
    logic [AW:0]           level;
    logic [AW:0]           high_water;
    logic                  in_fire;

    modport master (
        output flush, stream_in_valid, stream_in_data, stream_out_ready,
        input  stream_in_ready, stream_out_valid, stream_out_data, level, high_water, in_fire
    );

    modport slave (
        input  flush, stream_in_valid, stream_in_data, stream_out_ready,
        output stream_in_ready, stream_out_valid, stream_out_data, level, high_water, in_fire
    );
endinterface

// File: rtl/sample_stream_fifo.sv
// rtl/sample_stream_fifo.sv - ready/valid FIFO with occupancy, high-water mark and flush
// Optional zero-latency empty bypass: SAMPLE_STREAM_FIFO_BYPASS_EN.
module sample_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sample_stream_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt, high_water_q;
    logic        empty, full, stored_valid, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign stored_valid = !empty && !bus.flush;
    assign pop          = stored_valid && bus.stream_out_ready;

    assign bus.stream_in_ready = !full && !bus.flush;
    assign bus.in_fire         = bus.stream_in_valid && bus.stream_in_ready;
    assign bus.level           = wr_ptr - rd_ptr;
    assign bus.high_water      = high_water_q;

`ifdef SAMPLE_STREAM_FIFO_BYPASS_EN
    // An accepted word that meets an empty FIFO and a ready sink never touches storage.
    assign bus.stream_out_valid = stored_valid || (empty && bus.stream_in_valid && !bus.flush);
    assign bus.stream_out_data  = empty ? bus.stream_in_data : mem[rd_ptr[AW-1:0]];
    assign push                 = bus.in_fire && !(empty && bus.stream_out_ready);
`else
    assign bus.stream_out_valid = stored_valid;
    assign bus.stream_out_data  = mem[rd_ptr[AW-1:0]];
    assign push                 = bus.in_fire;
`endif

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (bus.flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        level_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            high_water_q <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (bus.flush)
                high_water_q <= '0;
            else if (level_nxt > high_water_q)
                high_water_q <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.stream_in_data;
    end
endmodule
